// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both sides,
// occupancy count, almost-full/almost-empty flags and synchronous flush.
// OREG=1 adds a flop-driven output stage that also holds one extra entry.
module sync_fifo_fwft #(
  parameter int DW     = 18,
  parameter int AW     = 7,
  parameter int OREG   = 0,
  parameter int AF_LVL = (2**AW) - 4,
  parameter int AE_LVL = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] in_data,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   count,
  output logic          almost_full,
  output logic          almost_empty
);

  localparam int DEPTH = 2**AW;
  localparam int CW    = AW + 1;
  localparam int CAP   = DEPTH + OREG;

  localparam logic [CW-1:0] CAP_C = CW'(CAP);
  localparam logic [CW-1:0] AF_C  = CW'(AF_LVL);
  localparam logic [CW-1:0] AE_C  = CW'(AE_LVL);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] mem_rdata;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic push;
  logic pop;
  logic mem_we;
  logic rd_adv;

  // Handshakes depend only on the count register, never on in_vld/out_rdy.
  assign in_rdy       = (count_q != CAP_C);
  assign out_vld      = (count_q != '0);
  assign push         = in_vld && in_rdy;
  assign pop          = out_vld && out_rdy;
  assign count        = count_q;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign mem_rdata    = mem[rd_ptr_q];

  // Next-state for pointers and occupancy; flush overrides any transfer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (mem_we) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_adv) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (mem_we && !flush) mem[wr_ptr_q] <= in_data;
  end

  generate
    if (OREG == 0) begin : g_comb_out
      assign mem_we   = push;
      assign rd_adv   = pop;
      assign out_data = mem_rdata;
    end else begin : g_reg_out
      // count includes the output register, so the array is empty at count <= 1.
      logic          arr_empty;
      logic          load_byp;
      logic          load_arr;
      logic [DW-1:0] odata_q, odata_d;

      assign arr_empty = (count_q <= CW'(1));
      assign load_byp  = push && ((count_q == '0) || (pop && arr_empty));
      assign load_arr  = pop && !arr_empty;
      assign mem_we    = push && !load_byp;
      assign rd_adv    = load_arr;
      assign out_data  = odata_q;

      // Output register takes bypassed input data or the next array entry.
      always_comb begin
        odata_d = odata_q;
        if (!flush) begin
          if (load_byp)      odata_d = in_data;
          else if (load_arr) odata_d = mem_rdata;
        end
      end

      // Output data register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) odata_q <= '0;
        else     odata_q <= odata_d;
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_fwft.sv
module tb_sync_fifo_fwft;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_vld;
  logic [17:0] in_data;
  logic        out_rdy;

  logic        rdy0, vld0, af0, ae0;
  logic [17:0] data0;
  logic [7:0]  cnt0;
  logic        rdy1, vld1, af1, ae1;
  logic [17:0] data1;
  logic [7:0]  cnt1;

  int checks = 0;
  int errors = 0;

  logic [17:0] q0[$];
  logic [17:0] q1[$];

  always #5 clk = ~clk;

  sync_fifo_fwft #(.OREG(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_vld(in_vld), .in_rdy(rdy0), .in_data(in_data),
    .out_vld(vld0), .out_rdy(out_rdy), .out_data(data0),
    .count(cnt0), .almost_full(af0), .almost_empty(ae0)
  );

  sync_fifo_fwft #(.OREG(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_vld(in_vld), .in_rdy(rdy1), .in_data(in_data),
    .out_vld(vld1), .out_rdy(out_rdy), .out_data(data1),
    .count(cnt1), .almost_full(af1), .almost_empty(ae1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input string n, input int cap, input int sz, input logic [17:0] fr,
                         input logic rdy, input logic vld, input logic [17:0] d,
                         input logic [7:0] c, input logic af, input logic ae);
    chk({n, "_in_rdy"},  32'(rdy), 32'(sz != cap));
    chk({n, "_out_vld"}, 32'(vld), 32'(sz != 0));
    chk({n, "_count"},   32'(c),   32'(sz));
    chk({n, "_afull"},   32'(af),  32'(sz >= 124));
    chk({n, "_aempty"},  32'(ae),  32'(sz <= 4));
    if (sz != 0) chk({n, "_out_data"}, 32'(d), 32'(fr));
  endtask

  task automatic check_all();
    chk_dut("oreg0", 128, q0.size(), (q0.size() != 0) ? q0[0] : 18'h0,
            rdy0, vld0, data0, cnt0, af0, ae0);
    chk_dut("oreg1", 129, q1.size(), (q1.size() != 0) ? q1[0] : 18'h0,
            rdy1, vld1, data1, cnt1, af1, ae1);
  endtask

  // One clock: predict transfers from the model, apply them at the edge, then check.
  task automatic step();
    bit p0, po0, p1, po1;
    p0  = in_vld  && (q0.size() != 128);
    po0 = out_rdy && (q0.size() != 0);
    p1  = in_vld  && (q1.size() != 129);
    po1 = out_rdy && (q1.size() != 0);
    @(posedge clk);
    if (flush) begin
      q0.delete();
      q1.delete();
    end else begin
      if (po0) void'(q0.pop_front());
      if (p0)  q0.push_back(in_data);
      if (po1) void'(q1.pop_front());
      if (p1)  q1.push_back(in_data);
    end
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;
    #3;
    check_all();
    chk("rst_odata1", 32'(data1), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Fill OREG=0 to capacity with 0..127.
    for (int i = 0; i < 128; i++) begin
      in_vld = 1'b1; in_data = 18'(i);
      step();
      if (i == 122) chk("af0_below_124", 32'(af0), 32'h0);
      if (i == 123) chk("af0_at_124", 32'(af0), 32'h1);
    end
    chk("full0_count", 32'(cnt0), 32'd128);
    chk("full0_in_rdy", 32'(rdy0), 32'h0);
    chk("oreg1_128_in_rdy", 32'(rdy1), 32'h1);

    // 129th word fits only in OREG=1.
    in_data = 18'd128;
    step();
    chk("full1_count", 32'(cnt1), 32'd129);
    chk("full1_in_rdy", 32'(rdy1), 32'h0);
    chk("full0_still_128", 32'(cnt0), 32'd128);

    // First pop with in_vld held; ready returns one cycle later.
    chk("head0_before_pop", 32'(data0), 32'h0);
    chk("head1_before_pop", 32'(data1), 32'h0);
    in_data = 18'd300; out_rdy = 1'b1;
    step();
    chk("rdy0_after_pop", 32'(rdy0), 32'h1);
    chk("rdy1_after_pop", 32'(rdy1), 32'h1);
    in_data = 18'd301;
    step();
    in_vld = 1'b0;
    for (int i = 0; i < 140; i++) step();
    chk("drain0_count", 32'(cnt0), 32'h0);
    chk("drain1_out_vld", 32'(vld1), 32'h0);

    // Single push into an empty FIFO appears the next cycle.
    out_rdy = 1'b0; in_vld = 1'b1; in_data = 18'h2A5;
    step();
    in_vld = 1'b0;
    chk("single0_data", 32'(data0), 32'h2A5);
    chk("single1_data", 32'(data1), 32'h2A5);
    chk("single1_vld", 32'(vld1), 32'h1);

    // Sustained push+pop at count 1; pointers wrap many times.
    in_vld = 1'b1; out_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      in_data = 18'(i * 7 + 3);
      step();
    end
    chk("stream0_count", 32'(cnt0), 32'h1);
    chk("stream1_count", 32'(cnt1), 32'h1);
    chk("stream1_data", 32'(data1), 32'(999 * 7 + 3));

    // Build to 50 entries, then flush with simultaneous push and pop.
    out_rdy = 1'b0;
    for (int i = 0; i < 49; i++) begin
      in_data = 18'(16'h4000 + i);
      step();
    end
    chk("pre_flush0_count", 32'(cnt0), 32'd50);
    flush = 1'b1; in_data = 18'h3FF; out_rdy = 1'b1;
    step();
    flush = 1'b0;
    chk("flush0_count", 32'(cnt0), 32'h0);
    chk("flush1_count", 32'(cnt1), 32'h0);
    chk("flush0_vld", 32'(vld0), 32'h0);
    out_rdy = 1'b0; in_data = 18'h001;
    step();
    in_vld = 1'b0;
    chk("post_flush0_data", 32'(data0), 32'h001);
    chk("post_flush1_data", 32'(data1), 32'h001);

    // Random traffic: fill-biased, then drain-biased.
    for (int i = 0; i < 900; i++) begin
      in_vld  = (i < 450) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      out_rdy = (i < 450) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      in_data = 18'($urandom);
      step();
    end

    // Asynchronous reset mid-burst, checked before the next edge.
    in_vld = 1'b1; out_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_data = 18'(i + 16'h1000);
      step();
    end
    #2;
    rst = 1'b1;
    #1;
    q0.delete();
    q1.delete();
    check_all();
    chk("arst_odata1", 32'(data1), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    in_data = 18'h00005;
    step();
    in_vld = 1'b0;
    chk("post_rst0_data", 32'(data0), 32'h5);
    chk("post_rst1_data", 32'(data1), 32'h5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_fwft.md
# sync_fifo_fwft

Parametrised single-clock first-word-fall-through FIFO with valid/ready handshakes on both sides, occupancy count, programmable almost-full/almost-empty flags and synchronous flush. Storage is an internal 2-port array (write at clock edge, asynchronous read). An optional registered output stage trades one extra entry of capacity for a flop-driven `out_data`. It is the standard buffering element between producer and consumer pipelines in the same clock domain.

## Interface
- `DW`, 18, data width in bits.
- `AW`, 7, array address width; the array holds DEPTH = 2**AW entries.
- `OREG`, 0, selects the output stage: 0 = `out_data` read combinationally from the array; 1 = registered output stage. CAP = DEPTH + OREG.
- `AF_LVL`, DEPTH-4, `almost_full` threshold; legal range 1..CAP.
- `AE_LVL`, 4, `almost_empty` threshold; legal range 0..CAP-1.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous clear; empties the FIFO.
- `in_vld`  in  1  producer has data.
- `in_rdy`  out  1  FIFO can accept data.
- `in_data`  in  DW  write data.
- `out_vld`  out  1  head entry valid.
- `out_rdy`  in  1  consumer takes the head entry.
- `out_data`  out  DW  head entry.
- `count`  out  AW+1  occupancy, 0..CAP.
- `almost_full`  out  1  `count >= AF_LVL`.
- `almost_empty`  out  1  `count <= AE_LVL`.

## Operation
- A push occurs when `in_vld && in_rdy`. A pop occurs when `out_vld && out_rdy`.
- `in_rdy = (count != CAP)`. When full, `in_rdy` stays 0 even if a pop occurs in the same cycle. No push-through-when-full.
- `out_vld = (count != 0)`. FIFO order is strict; no entry is dropped or duplicated.
- Write and read pointers are AW bits wide and wrap modulo DEPTH with no special handling.
- Count update per cycle: push only → +1; pop only → -1; push and pop together → unchanged.
- OREG=0:
  - `out_data = mem[rd_ptr]` (combinational).
  - A push writes `mem[wr_ptr]`; a pop advances `rd_ptr`.
- OREG=1: the output register holds the head entry whenever `count != 0`.
  - On a push with the output register empty, or being popped while the array is empty, data bypasses the array straight into the output register.
  - On a pop with a non-empty array, the output register loads `mem[rd_ptr]` and `rd_ptr` advances.
  - Otherwise the push goes to the array.
- `flush`:
  - On the edge it is sampled high, pointers, count and the output-register valid are cleared.
  - Any push or pop in that cycle is discarded. `flush` has priority over both.
  - Handshakes are still presented combinationally during the flush cycle; producer and consumer must treat that cycle's transfer as lost.
- The array is never reset. `out_data` is don't-care while `out_vld` = 0.
- `almost_full` and `almost_empty` are decoded combinationally from the `count` register.

## Timing
- Reset values:
  - `in_rdy` = 1, `out_vld` = 0, `count` = 0, `almost_empty` = 1, `almost_full` = 0.
  - OREG=1 output data register = 0.
- Reset assertion clears state immediately, regardless of the clock. Deassertion is synchronous-safe: the first push may occur on the first edge after deassertion.
- Reset in mid-operation discards all contents. Behaviour is identical to power-up.
- Write-to-read latency is 1 in both modes: a push on edge N gives `out_vld` = 1 with that data in the cycle after edge N.
- Throughput is one push and one pop per cycle, sustained, whenever 0 < count < CAP.
- Flags and `in_rdy`/`out_vld` change only after clock edges. `in_rdy` and `out_vld` do not combinationally depend on `in_vld` or `out_rdy`.
- Simultaneous push and pop at count = 1 (OREG=1): the output register takes the new data via bypass, and `count` stays 1.

## Test plan
- Reset then idle → `in_rdy` = 1, `out_vld` = 0, `count` = 0, `almost_empty` = 1, `almost_full` = 0. Assert `rst` asynchronously mid-burst → outputs return to these values before the next edge.
- Default params, OREG=0: push 0..127 with `out_rdy` = 0 → `in_rdy` falls after the 128th push, `count` = 128, `almost_full` rises when `count` = 124. Then pop all → data 0..127 in order, `almost_empty` rises at `count` = 4.
- OREG=1: push 129 words → `count` = 129 and `in_rdy` = 0. Pop with `in_vld` held → ordering preserved; `in_rdy` returns one cycle after the first pop.
- Continuous push and pop for 1000 cycles from `count` = 1 → `count` stays 1, pointers wrap 7+ times, and output equals input delayed by one entry. Repeat with random `in_vld`/`out_rdy` and check against a scoreboard in both OREG modes.
- Single push of 0x2A5 into an empty FIFO → `out_vld` = 1 and `out_data` = 0x2A5 the next cycle (both modes).
- `flush` at `count` = 50 with simultaneous push and pop → next cycle `count` = 0 and `out_vld` = 0. A subsequent push of 0x001 is the next word output.
